// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard/forwarding controller.
//   - EX operand forwarding-select encodings.
//   - Shadow-stage record layout and its width as a function of the
//     register-address width. Field order, MSB to LSB:
//       {v, rd, rs1, rs2, rs1_used, rs2_used, reg_write, mem_read}
package hazard_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // Single-bit fields: v, rs1_used, rs2_used, reg_write, mem_read.
    localparam int unsigned STAGE_FLAG_W = 5;

    // Total shadow-record width for a given register-address width.
    function automatic int unsigned stage_w(input int unsigned ra_w);
        return 3 * ra_w + STAGE_FLAG_W;
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// hazard_stage_reg: one shadow pipeline stage of the hazard controller.
// Ports:
//   i_clk     system clock
//   i_rst_n   asynchronous active-low reset, clears the record
//   i_bubble  load an all-zero record (bubble) instead of i_d
//   i_d       incoming shadow record
//   o_q       registered shadow record
module hazard_stage_reg
    import hazard_pkg::*;
#(
    parameter int unsigned W = stage_w(5)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_bubble,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_bubble) begin
            r_q <= '0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use hazard detection, stall/flush generation and EX
// operand forwarding selection for the 5-stage core.
// Ports:
//   clk, rstn            clock; asynchronous active-low reset
//   id_*                 decoded fields of the instruction currently in ID
//   ex_br_taken          branch/jump resolved taken in EX this cycle
//   pc_wen, if_id_wen    PC and IF/ID write enables (low during a stall)
//   if_id_clear          flush IF/ID (taken branch)
//   id_ex_clear          ID/EX clear, inserts a bubble (branch or stall)
//   fwd_a_sel/fwd_b_sel  EX operand sources (see hazard_pkg FWD_*)
//   stall_cnt/flush_cnt  wrapping event counters for debug readout
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned RA_W  = 5,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             ex_br_taken,
    output logic             pc_wen,
    output logic             if_id_wen,
    output logic             if_id_clear,
    output logic             id_ex_clear,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned SW = stage_w(RA_W);

    typedef struct packed {
        logic            v;
        logic [RA_W-1:0] rd;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic            rs1_used;
        logic            rs2_used;
        logic            reg_write;
        logic            mem_read;
    } stage_t;

    stage_t w_id, w_ex, w_mem, w_wb;
    logic [SW-1:0] w_ex_q, w_mem_q, w_wb_q;
    logic w_br, w_lu;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    assign w_id = '{v:         id_valid,
                    rd:        id_rd,
                    rs1:       id_rs1,
                    rs2:       id_rs2,
                    rs1_used:  id_rs1_used,
                    rs2_used:  id_rs2_used,
                    reg_write: id_reg_write,
                    mem_read:  id_mem_read};

    // ID/EX is written every cycle; a clear turns the slot into a bubble.
    hazard_stage_reg #(.W(SW)) u_ex (
        .i_clk    (clk),
        .i_rst_n  (rstn),
        .i_bubble (id_ex_clear),
        .i_d      (w_id),
        .o_q      (w_ex_q)
    );

    hazard_stage_reg #(.W(SW)) u_mem (
        .i_clk    (clk),
        .i_rst_n  (rstn),
        .i_bubble (1'b0),
        .i_d      (w_ex_q),
        .o_q      (w_mem_q)
    );

    hazard_stage_reg #(.W(SW)) u_wb (
        .i_clk    (clk),
        .i_rst_n  (rstn),
        .i_bubble (1'b0),
        .i_d      (w_mem_q),
        .o_q      (w_wb_q)
    );

    assign w_ex  = w_ex_q;
    assign w_mem = w_mem_q;
    assign w_wb  = w_wb_q;

    // Qualified by rstn so the control outputs sit at their reset values
    // for as long as reset is held, whatever ex_br_taken does.
    assign w_br = ex_br_taken & rstn;

    assign w_lu = id_valid & w_ex.v & w_ex.mem_read & (w_ex.rd != '0) &
                  ((id_rs1_used & (id_rs1 == w_ex.rd)) |
                   (id_rs2_used & (id_rs2 == w_ex.rd)));

    always_comb begin
        pc_wen      = 1'b1;
        if_id_wen   = 1'b1;
        if_id_clear = 1'b0;
        id_ex_clear = 1'b0;
        if (w_br) begin
            if_id_clear = 1'b1;
            id_ex_clear = 1'b1;
        end else if (w_lu) begin
            pc_wen      = 1'b0;
            if_id_wen   = 1'b0;
            id_ex_clear = 1'b1;
        end
    end

    // MEM beats WB (youngest producer); loads are never taken from MEM.
    function automatic logic [1:0] fwd_sel(input logic            used,
                                           input logic [RA_W-1:0] rs,
                                           input stage_t          mem,
                                           input stage_t          wb);
        if (mem.v && mem.reg_write && !mem.mem_read && (mem.rd != '0) &&
            used && (mem.rd == rs)) begin
            return FWD_EXMEM;
        end else if (wb.v && wb.reg_write && (wb.rd != '0) &&
                     used && (wb.rd == rs)) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

    always_comb begin
        fwd_a_sel = fwd_sel(w_ex.rs1_used, w_ex.rs1, w_mem, w_wb);
        fwd_b_sel = fwd_sel(w_ex.rs2_used, w_ex.rs2, w_mem, w_wb);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (w_br) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end else if (w_lu) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and forwarding controller for the 5-stage core. It is the producer side of the ID/EX register's `clear` input and of the EX operand-mux selects.
- Keeps a registered shadow of the destination and control bits of the instructions in EX, MEM and WB.
- From that shadow it detects load-use hazards, generates stall and flush, and selects EX forwarding sources.
- Also counts stall and flush events for debug readout.

Parameters:
- RA_W, 5, register-address width
- CNT_W, 32, width of the stall and flush event counters

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  RA_W  ID source register 1
- id_rs2  in  RA_W  ID source register 2
- id_rs1_used  in  1  ID instruction reads rs1
- id_rs2_used  in  1  ID instruction reads rs2
- id_rd  in  RA_W  ID destination register
- id_reg_write  in  1  ID instruction writes the register file
- id_mem_read  in  1  ID instruction is a load
- ex_br_taken  in  1  branch or jump resolved taken in EX this cycle
- pc_wen  out  1  PC write enable
- if_id_wen  out  1  IF/ID write enable
- if_id_clear  out  1  flush IF/ID
- id_ex_clear  out  1  drives the ID/EX `clear` input (bubble insert)
- fwd_a_sel  out  2  EX operand A: 00 register file, 01 EX/MEM ALU result, 10 MEM/WB write-back data
- fwd_b_sel  out  2  EX operand B, same encoding as fwd_a_sel
- stall_cnt  out  CNT_W  load-use stall cycles since reset
- flush_cnt  out  CNT_W  taken-branch flushes since reset

Behaviour:
- Clock and reset: one clock `clk`. Reset `rstn` is asynchronous and active-low.
- State: three shadow stages, EX, MEM and WB.
  - Each stage holds {v, rd, rs1, rs2, rs1_used, rs2_used, reg_write, mem_read}.
  - All stages advance every clock edge, matching the ID/EX register's permanent write enable.
  - MEM <= EX and WB <= MEM.
  - EX <= ID inputs, with v = id_valid & ~id_ex_clear. A cleared slot is a bubble: v=0 and all control bits 0.
- Reset values:
  - All shadow stages have v=0 and zero fields.
  - stall_cnt = 0 and flush_cnt = 0.
  - Combinational outputs then evaluate to pc_wen=1, if_id_wen=1, if_id_clear=0, id_ex_clear=0, fwd_a_sel=00, fwd_b_sel=00.
- Load-use hazard (lu):
  - lu = id_valid & EX.v & EX.mem_read & EX.rd!=0 & ((id_rs1_used & id_rs1==EX.rd) | (id_rs2_used & id_rs2==EX.rd)).
- Control outputs (combinational, same cycle):
  - ex_br_taken=1: if_id_clear=1, id_ex_clear=1, pc_wen=1, if_id_wen=1. The branch has priority and any simultaneous lu is discarded.
  - else lu=1: pc_wen=0, if_id_wen=0, id_ex_clear=1, if_id_clear=0. This gives exactly one bubble; the next cycle sees the load in MEM, lu=0, and forwarding takes over.
  - else: pc_wen=1, if_id_wen=1, both clears 0.
- Forwarding (combinational from shadow state only, no dependence on ID inputs):
  - fwd_a_sel=01 if MEM.v & MEM.reg_write & ~MEM.mem_read & MEM.rd!=0 & EX.rs1_used & MEM.rd==EX.rs1.
  - else fwd_a_sel=10 if WB.v & WB.reg_write & WB.rd!=0 & EX.rs1_used & WB.rd==EX.rs1.
  - else fwd_a_sel=00.
  - fwd_b_sel follows the same rules using rs2.
  - MEM has priority over WB, so the youngest producer wins.
  - A load in MEM is never forwarded from MEM; the lu stall guarantees it reaches WB first.
  - The register file is write-first, so there is no WB-to-ID bypass here.
- Counters:
  - stall_cnt increments on each edge where lu=1 and ex_br_taken=0.
  - flush_cnt increments on each edge where ex_br_taken=1.
  - Both counters wrap modulo 2^CNT_W.
- Reset mid-operation: asserting rstn=0 asynchronously clears all shadows and counters, and the outputs return to their reset values immediately.
- x0: rd=0 never causes a stall or a forward.

Decomposition:
- Shared package `hazard_pkg`:
  - FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10
  - stage-shadow record layout and width constant
- One sub-module, `hazard_stage_reg`: the shadow-stage register with async active-low reset and a bubble input, instantiated three times.

Test Plan:
1. Reset: rstn=0 for 3 cycles with random inputs -> pc_wen=1, if_id_wen=1, both clears 0, fwd selects 00, both counters 0.
2. Load-use: load writing x5, then ID presents add with rs1=x5 -> one cycle with pc_wen=0, if_id_wen=0, id_ex_clear=1; one cycle later fwd_a_sel=10 when the add is in EX; stall_cnt=1.
3. ALU back-to-back: add writing x3, then sub with rs2=x3 -> no stall; fwd_b_sel=01 when sub is in EX. Insert one unrelated instruction between them -> fwd_b_sel=10.
4. Double producer: x7 written in MEM and in WB, EX reads x7 on rs1 -> fwd_a_sel=01.
5. Branch with simultaneous load-use: ex_br_taken=1 in the same cycle lu=1 -> if_id_clear=1, id_ex_clear=1, pc_wen=1; flush_cnt=1, stall_cnt unchanged.
6. x0 and wrap: load to x0 with a consumer reading x0 -> no stall, fwd 00. Run with CNT_W=4 and 17 stalls -> stall_cnt=1.
